// File: rtl/blake2_pkg.sv
// Shared definitions for the blake2 message feeder: default geometry and the feeder state encoding.
package blake2_pkg;

  localparam int unsigned BB_DEFAULT        = 128;
  localparam int unsigned KEY_BYTES_DEFAULT = 64;
  localparam int unsigned BYTE_IDX_W        = $clog2(BB_DEFAULT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_MSG,
    S_PAD,
    S_DONE
  } state_e;

endpackage

// File: rtl/blake2_msg_feeder.sv
// Feeds the blake2 core: optional zero-padded key block, message pass-through, zero pad to BB.
// Keyed hashing is compiled in only when BLAKE2_KEY_EN is defined.
module blake2_msg_feeder
  import blake2_pkg::*;
#(
  parameter int unsigned BB        = BB_DEFAULT,
  parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int unsigned LL_W      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [7:0]             kk_i,
  input  logic [7:0]             nn_i,
  input  logic [KEY_BYTES*8-1:0] key_i,
  input  logic                   empty_i,
  input  logic                   msg_v_i,
  input  logic [7:0]             msg_i,
  input  logic                   msg_last_i,
  output logic                   msg_ready_o,
  input  logic                   core_ready_i,
  output logic                   data_v_o,
  output logic [7:0]             data_o,
  output logic                   block_first_o,
  output logic                   block_last_o,
  output logic [LL_W-1:0]        ll_o,
  output logic [7:0]             kk_o,
  output logic [7:0]             nn_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned      IDX_W    = $clog2(BB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BB - 1);
  localparam logic [LL_W-1:0]  LL_MAX   = '1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q;
  logic             first_q;
  logic             empty_q;
  logic [LL_W-1:0]  ll_q, ll_inc;
  logic [7:0]       kk_q, nn_q;
  logic [7:0]       key_byte;
  logic             keyed_start;
  logic             xfer;
  logic             blk_end;

`ifdef BLAKE2_KEY_EN
  localparam int unsigned KIDX_W = $clog2(KEY_BYTES);
  logic [7:0]        key_q [KEY_BYTES];
  logic [KIDX_W-1:0] key_idx;

  assign keyed_start = (kk_i != 8'd0);
  assign key_idx     = byte_idx_q[KIDX_W-1:0];
  assign key_byte    = (int'(byte_idx_q) < int'(kk_q) && int'(byte_idx_q) < int'(KEY_BYTES)) ?
                       key_q[key_idx] : 8'h00;

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start_i) begin
      for (int j = 0; j < int'(KEY_BYTES); j++) key_q[j] <= key_i[8*j +: 8];
    end
  end
`else
  logic unused_key_in;
  assign unused_key_in = ^{kk_i, key_i};
  assign keyed_start   = 1'b0;
  assign key_byte      = 8'h00;
`endif

  assign ll_inc  = (ll_q == LL_MAX) ? ll_q : ll_q + LL_W'(1);
  assign blk_end = (byte_idx_q == LAST_IDX);
  assign xfer    = data_v_o & core_ready_i;

  always_comb begin
    state_d      = state_q;
    data_v_o     = 1'b0;
    data_o       = 8'h00;
    msg_ready_o  = 1'b0;
    block_last_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = keyed_start ? S_KEY : (empty_i ? S_PAD : S_MSG);
      end
`ifdef BLAKE2_KEY_EN
      S_KEY: begin
        data_v_o     = 1'b1;
        data_o       = key_byte;
        block_last_o = empty_q;
        if (core_ready_i && blk_end) state_d = empty_q ? S_DONE : S_MSG;
      end
`endif
      S_MSG: begin
        data_v_o     = msg_v_i;
        data_o       = msg_i;
        msg_ready_o  = core_ready_i;
        block_last_o = msg_v_i & msg_last_i;
        if (msg_v_i && core_ready_i && msg_last_i) state_d = blk_end ? S_DONE : S_PAD;
      end
      S_PAD: begin
        data_v_o     = 1'b1;
        block_last_o = 1'b1;
        if (core_ready_i && blk_end) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      first_q    <= 1'b0;
      empty_q    <= 1'b0;
      ll_q       <= '0;
      kk_q       <= 8'd0;
      nn_q       <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        byte_idx_q <= '0;
        first_q    <= 1'b1;
        empty_q    <= empty_i;
        ll_q       <= keyed_start ? LL_W'(BB) : '0;
`ifdef BLAKE2_KEY_EN
        kk_q       <= kk_i;
`else
        kk_q       <= 8'd0;
`endif
        nn_q       <= nn_i;
      end else if (xfer) begin
        byte_idx_q <= blk_end ? '0 : byte_idx_q + IDX_W'(1);
        if (blk_end) first_q <= 1'b0;
        if (state_q == S_MSG) ll_q <= ll_inc;
      end
    end
  end

  // In S_MSG the byte on the bus is not yet counted, so report the total including it.
  assign ll_o          = (state_q == S_MSG) ? ll_inc : ll_q;
  assign block_first_o = first_q;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Scoreboard bench for blake2_msg_feeder; keyed cases run only when BLAKE2_KEY_EN is defined.
module tb_blake2_msg_feeder;

  localparam int BB = 128;
  localparam int KB = 64;
  localparam int LW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic [7:0]    kk_i = 8'd0;
  logic [7:0]    nn_i = 8'd0;
  logic [KB*8-1:0] key_i = '0;
  logic          empty_i = 1'b0;
  logic          msg_v_i = 1'b0;
  logic [7:0]    msg_i = 8'd0;
  logic          msg_last_i = 1'b0;
  logic          msg_ready_o;
  logic          core_ready_i = 1'b0;
  logic          data_v_o;
  logic [7:0]    data_o;
  logic          block_first_o;
  logic          block_last_o;
  logic [LW-1:0] ll_o;
  logic [7:0]    kk_o;
  logic [7:0]    nn_o;
  logic          busy_o;
  logic          done_o;

  blake2_msg_feeder #(.BB(BB), .KEY_BYTES(KB), .LL_W(LW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .key_i(key_i),
    .empty_i(empty_i), .msg_v_i(msg_v_i), .msg_i(msg_i), .msg_last_i(msg_last_i),
    .msg_ready_o(msg_ready_o), .core_ready_i(core_ready_i), .data_v_o(data_v_o),
    .data_o(data_o), .block_first_o(block_first_o), .block_last_o(block_last_o),
    .ll_o(ll_o), .kk_o(kk_o), .nn_o(nn_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    logic [7:0]  d;
    logic        first;
    logic        last;
    logic [63:0] ll;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] key_byte(input int j);
    return 8'(32'hA5 ^ (j * 3));
  endfunction

  // Monitor: every transfer to the core pops one expected byte.
  always @(negedge clk) begin
    if (!reset && data_v_o && core_ready_i) begin
      if (sb.size() == 0) chk("sb_extra_byte", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", 64'(data_o), 64'(e.d));
        chk("first", 64'(block_first_o), 64'(e.first));
        chk("last", 64'(block_last_o), 64'(e.last));
        if (e.last) chk("ll", ll_o, e.ll);
        if (sb.size() == 0) last_xfer_cyc = cyc;
      end
    end
  end

  task automatic build_exp(input int kk, input int len, input bit abc);
    int base, ntot, nb;
    exp_t e;
    m.delete();
    for (int i = 0; i < len; i++) m.push_back(abc ? 8'(32'h61 + i) : 8'(i * 7 + 1));
    base = (kk > 0) ? BB : 0;
    ntot = base + len;
    nb   = (ntot + BB - 1) / BB;
    if (nb == 0) nb = 1;
    for (int i = 0; i < nb * BB; i++) begin
      e.first = (i < BB);
      e.ll    = 64'(ntot);
      if (i < base) begin
        e.d    = (i < kk) ? key_byte(i) : 8'h00;
        e.last = (len == 0);
      end else if (i < base + len) begin
        e.d    = m[i - base];
        e.last = (i == base + len - 1);
      end else begin
        e.d    = 8'h00;
        e.last = 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic run_msg(input int kk, input int len, input bit abc, input bit toggle,
                         input logic [7:0] nn);
    int  idx;
    bit  seen_done, accepted;
    build_exp(kk, len, abc);
    @(posedge clk); #1;
    start_i      = 1'b1;
    kk_i         = 8'(kk);
    nn_i         = nn;
    empty_i      = (len == 0);
    core_ready_i = 1'b1;
    msg_v_i      = (len > 0);
    msg_i        = (len > 0) ? m[0] : 8'h00;
    msg_last_i   = (len == 1);
    idx          = 0;
    seen_done    = 1'b0;
    for (int c = 0; c < 2000 && !seen_done; c++) begin
      @(negedge clk);
      accepted = msg_v_i && msg_ready_o;
      if (msg_ready_o || !core_ready_i) chk("msg_ready", 64'(msg_ready_o), 64'(core_ready_i));
      if (done_o) begin
        seen_done = 1'b1;
        chk("done_latency", 64'(cyc), 64'(last_xfer_cyc + 1));
        chk("kk_o", 64'(kk_o), 64'(kk));
        chk("nn_o", 64'(nn_o), 64'(nn));
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (accepted) idx++;
      msg_v_i      = (idx < len);
      msg_i        = (idx < len) ? m[idx] : 8'h00;
      msg_last_i   = (idx == len - 1);
      core_ready_i = toggle ? ~core_ready_i : 1'b1;
    end
    if (!seen_done) chk("done_timeout", 64'd0, 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("msg_consumed", 64'(idx), 64'(len));
    @(negedge clk);
    chk("done_pulse", 64'(done_o), 64'd0);
    chk("idle_after", 64'(busy_o), 64'd0);
  endtask

  initial begin
    for (int j = 0; j < KB; j++) key_i[8*j +: 8] = key_byte(j);
    @(posedge clk); @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_data_v", 64'(data_v_o), 64'd0);
    chk("rst_ll", ll_o, 64'd0);
    chk("rst_kk", 64'(kk_o), 64'd0);
    chk("rst_nn", 64'(nn_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_msg(0, 3, 1'b1, 1'b0, 8'd64);    // "abc"
    run_msg(0, 128, 1'b0, 1'b0, 8'd32);  // exactly one block
    run_msg(0, 129, 1'b0, 1'b0, 8'd48);  // one byte into the second block
    run_msg(0, 0, 1'b0, 1'b0, 8'd64);    // empty, unkeyed
`ifdef BLAKE2_KEY_EN
    run_msg(64, 0, 1'b0, 1'b0, 8'd64);
    run_msg(32, 3, 1'b1, 1'b0, 8'd64);
`endif
    run_msg(0, 5, 1'b0, 1'b1, 8'd20);    // core_ready toggling

    // Reset while padding an empty message.
    build_exp(0, 0, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b1; kk_i = 8'd0; nn_i = 8'd9; empty_i = 1'b1; core_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pad_busy", 64'(busy_o), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    core_ready_i = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_data_v", 64'(data_v_o), 64'd0);
    chk("mid_rst_first", 64'(block_first_o), 64'd0);
    chk("mid_rst_last", 64'(block_last_o), 64'd0);
    chk("mid_rst_ll", ll_o, 64'd0);
    chk("mid_rst_nn", 64'(nn_o), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
